// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle ALU.
//   Request side : in_valid/in_ready handshake with opA, opB, op.
//   Response side: out_valid/out_ready handshake with result and flags
//                  (carry, zero, gt, overflow, negative, div_zero).
// master = producer of operations / consumer of results (pipeline side).
// slave  = the ALU.
interface alu_mc_if #(
  parameter int N = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] opA;
  logic [N-1:0] opB;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         carry;
  logic         zero;
  logic         gt;
  logic         overflow;
  logic         negative;
  logic         div_zero;

  modport master (
    output in_valid, opA, opB, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, gt, overflow, negative, div_zero
  );

  modport slave (
    input  in_valid, opA, opB, op, out_ready,
    output in_ready, out_valid, result, carry, zero, gt, overflow, negative, div_zero
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with registered outputs.
//   Single-cycle ops complete in one cycle; mul (shift-add) and divu/remu
//   (restoring) iterate N cycles. The block stalls the pipeline via
//   in_ready / out_valid while an operation is in flight or unconsumed.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   flush  - synchronous abort, returns to IDLE and drops any result
//   bus    - alu_mc_if.slave: request/response handshakes, operands, result, flags
//
// state  | meaning
// IDLE   | in_ready=1, waiting for an operation
// MUL    | shift-add iterations, counter 0..N-1
// DIV    | restoring-divide iterations, counter 0..N-1
// DONE   | out_valid=1, result/flags held until out_ready
module alu_mc #(
  parameter int N      = 24,
  parameter int SH_LSB = 4,
  parameter int SW     = $clog2(N)
) (
  input logic    clk,
  input logic    rst_n,
  input logic    flush,
  alu_mc_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [SW:0]   N_W      = (SW + 1)'(N);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_XOR  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_op;
  logic [2*N-1:0]  r_mcand;
  logic [2*N-1:0]  r_prod;
  logic [N-1:0]    r_mplier;
  logic [N-1:0]    r_quo;
  logic [N-1:0]    r_dvs;
  logic [N-1:0]    r_rem;
  logic            r_out_valid;
  logic [N-1:0]    r_result;
  logic            r_carry;
  logic            r_zero;
  logic            r_gt;
  logic            r_overflow;
  logic            r_negative;
  logic            r_div_zero;

  // ---------------- single-cycle datapath (from live operands) ----------
  logic [N:0]      w_add;
  logic [N:0]      w_sub;
  logic [SW-1:0]   w_amt;
  logic            w_amt_big;
  logic            w_b_zero;
  logic [N-1:0]    w_sc_result;
  logic            w_sc_carry;
  logic            w_sc_gt;
  logic            w_sc_ovf;
  logic            w_sc_arith;
  logic            w_sc_dz;

  assign w_add     = {1'b0, bus.opA} + {1'b0, bus.opB};
  assign w_sub     = {1'b0, bus.opA} + {1'b0, ~bus.opB} + {{N{1'b0}}, 1'b1};
  assign w_amt     = bus.opB[SH_LSB +: SW];
  assign w_amt_big = ({1'b0, w_amt} >= N_W);
  assign w_b_zero  = (bus.opB == '0);

  always_comb begin
    w_sc_result = '0;
    w_sc_carry  = 1'b0;
    w_sc_gt     = 1'b0;
    w_sc_ovf    = 1'b0;
    w_sc_arith  = 1'b0;
    w_sc_dz     = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_sc_result = w_add[N-1:0];
        w_sc_carry  = w_add[N];
        w_sc_ovf    = (bus.opA[N-1] == bus.opB[N-1]) & (w_add[N-1] != bus.opA[N-1]);
        w_sc_arith  = 1'b1;
      end
      OP_SUB: begin
        w_sc_result = w_sub[N-1:0];
        w_sc_carry  = w_sub[N];
        w_sc_ovf    = (bus.opA[N-1] != bus.opB[N-1]) & (w_sub[N-1] != bus.opA[N-1]);
        // signed A>B: nonzero difference whose sign agrees with overflow
        w_sc_gt     = (w_sub[N-1:0] != '0) & (w_sub[N-1] == w_sc_ovf);
        w_sc_arith  = 1'b1;
      end
      OP_XOR:  w_sc_result = bus.opA ^ bus.opB;
      OP_SLTU: w_sc_result = {{(N-1){1'b0}}, (bus.opA < bus.opB)};
      OP_SLT:  w_sc_result = {{(N-1){1'b0}}, ($signed(bus.opA) < $signed(bus.opB))};
      OP_SLL:  w_sc_result = w_amt_big ? '0 : (bus.opA << w_amt);
      OP_SRL:  w_sc_result = w_amt_big ? '0 : (bus.opA >> w_amt);
      OP_SRA:  w_sc_result = w_amt_big ? {N{bus.opA[N-1]}}
                                       : $unsigned($signed(bus.opA) >>> w_amt);
      // only reached with opB==0: divide-by-zero finishes immediately
      OP_DIVU: begin
        w_sc_result = '1;
        w_sc_dz     = 1'b1;
        w_sc_arith  = 1'b1;
      end
      OP_REMU: begin
        w_sc_result = bus.opA;
        w_sc_dz     = 1'b1;
        w_sc_arith  = 1'b1;
      end
      default: w_sc_result = '0;
    endcase
  end

  // ---------------- iterative datapath ----------------------------------
  logic [2*N-1:0]  w_prod_nxt;
  logic [N:0]      w_rem_sh;
  logic            w_qbit;
  logic [N-1:0]    w_rem_nxt;
  logic [N-1:0]    w_quo_nxt;
  logic [N-1:0]    w_div_res;

  assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  // Shifted partial remainder may carry into bit N; if so it certainly
  // exceeds the divisor, and the N-bit modular difference is exact.
  assign w_rem_sh  = {r_rem, r_quo[N-1]};
  assign w_qbit    = w_rem_sh[N] | (w_rem_sh[N-1:0] >= r_dvs);
  assign w_rem_nxt = w_qbit ? (w_rem_sh[N-1:0] - r_dvs) : w_rem_sh[N-1:0];
  assign w_quo_nxt = {r_quo[N-2:0], w_qbit};
  assign w_div_res = (r_op == OP_REMU) ? w_rem_nxt : w_quo_nxt;

  // ---------------- control FSM -----------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_gt        <= 1'b0;
      r_overflow  <= 1'b0;
      r_negative  <= 1'b0;
      r_div_zero  <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op  <= bus.op;
            r_cnt <= '0;
            if (bus.op == OP_MUL) begin
              r_mcand  <= {{N{1'b0}}, bus.opA};
              r_mplier <= bus.opB;
              r_prod   <= '0;
              r_state  <= S_MUL;
            end else if ((bus.op == OP_DIVU || bus.op == OP_REMU) && !w_b_zero) begin
              r_quo   <= bus.opA;
              r_dvs   <= bus.opB;
              r_rem   <= '0;
              r_state <= S_DIV;
            end else begin
              r_result    <= w_sc_result;
              r_carry     <= w_sc_carry;
              r_zero      <= w_sc_arith & (w_sc_result == '0);
              r_gt        <= w_sc_gt;
              r_overflow  <= w_sc_ovf;
              r_negative  <= w_sc_arith & w_sc_result[N-1];
              r_div_zero  <= w_sc_dz;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result    <= w_prod_nxt[N-1:0];
            r_carry     <= |w_prod_nxt[2*N-1:N];
            r_overflow  <= |w_prod_nxt[2*N-1:N];
            r_zero      <= (w_prod_nxt[N-1:0] == '0);
            r_negative  <= w_prod_nxt[N-1];
            r_gt        <= 1'b0;
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result    <= w_div_res;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= (w_div_res == '0);
            r_negative  <= w_div_res[N-1];
            r_gt        <= 1'b0;
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  assign bus.gt        = r_gt;
  assign bus.overflow  = r_overflow;
  assign bus.negative  = r_negative;
  assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc (N=24).
// Flags are compared as {carry, zero, gt, overflow, negative, div_zero}.
module tb_alu_mc;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_chk;
  int   n_pass;

  alu_mc_if #(.N(24)) bus();

  alu_mc #(.N(24), .SH_LSB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {bus.carry, bus.zero, bus.gt, bus.overflow, bus.negative, bus.div_zero};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op, measure latency, check result/flags, optionally hold
  // out_ready low for 'hold' cycles, then consume.
  task automatic run(input string tag, input logic [3:0] op, input logic [23:0] a,
                     input logic [23:0] b, input logic [23:0] er, input logic [5:0] ef,
                     input int elat, input int hold);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.opA       = a;
    bus.opB       = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.opA      = ~a;
    bus.opB      = ~b;
    bus.op       = ~op;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && elat > 1) chk({tag, " busy_in_ready"}, 32'(bus.in_ready), 32'd0);
    end while (!bus.out_valid && lat < 100);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " result"}, 32'(bus.result), 32'(er));
    chk({tag, " flags"}, 32'(flags()), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " hold_result"}, 32'(bus.result), 32'(er));
      chk({tag, " hold_flags"}, 32'(flags()), 32'(ef));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " drop_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opA       = '0;
    bus.opB       = '0;
    bus.op        = '0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", 32'(bus.result), 32'd0);
    chk("rst flags", 32'(flags()), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    //   tag          op     A          B          result     flags      lat hold
    run("add_ovf",   4'd0,  24'h7FFFFF, 24'h000001, 24'h800000, 6'b000110, 1, 5);
    run("add_carry", 4'd0,  24'hFFFFFF, 24'h000001, 24'h000000, 6'b110000, 1, 0);
    run("sub_eq",    4'd2,  24'd5,      24'd5,      24'h000000, 6'b110000, 1, 0);
    run("sub_gt",    4'd2,  24'd7,      24'd3,      24'h000004, 6'b101000, 1, 0);
    run("sub_lt",    4'd2,  24'd3,      24'd7,      24'hFFFFFC, 6'b000010, 1, 0);
    run("mul_big",   4'd6,  24'h001000, 24'h001000, 24'h000000, 6'b110100, 25, 0);
    run("mul_small", 4'd6,  24'd3,      24'd5,      24'd15,     6'b000000, 25, 0);
    run("divu",      4'd9,  24'd100,    24'd7,      24'd14,     6'b000000, 25, 0);
    run("remu",      4'd10, 24'd100,    24'd7,      24'd2,      6'b000000, 25, 0);
    run("divu_big",  4'd9,  24'hFFFFFF, 24'h000010, 24'h0FFFFF, 6'b000000, 25, 0);
    run("remu_big",  4'd10, 24'hFFFFFF, 24'h000010, 24'h00000F, 6'b000000, 25, 0);
    run("divu_z",    4'd9,  24'd9,      24'd0,      24'hFFFFFF, 6'b000011, 1, 0);
    run("remu_z",    4'd10, 24'd9,      24'd0,      24'd9,      6'b000001, 1, 0);
    run("sll_23",    4'd4,  24'h000001, 24'h000170, 24'h800000, 6'b000000, 1, 0);
    run("sll_24",    4'd4,  24'h000001, 24'h000180, 24'h000000, 6'b000000, 1, 0);
    run("srl_4",     4'd5,  24'h800000, 24'h000040, 24'h080000, 6'b000000, 1, 0);
    run("srl_31",    4'd5,  24'h800000, 24'h0001F0, 24'h000000, 6'b000000, 1, 0);
    run("sra_4",     4'd7,  24'h800000, 24'h000040, 24'hF80000, 6'b000000, 1, 0);
    run("sra_31",    4'd7,  24'h800000, 24'h0001F0, 24'hFFFFFF, 6'b000000, 1, 0);
    run("xor",       4'd1,  24'hA5A5A5, 24'h0F0F0F, 24'hAAAAAA, 6'b000000, 1, 0);
    run("sltu",      4'd3,  24'hFFFFFF, 24'h000001, 24'h000000, 6'b000000, 1, 0);
    run("slt",       4'd8,  24'hFFFFFF, 24'h000001, 24'h000001, 6'b000000, 1, 0);
    run("rsvd",      4'd13, 24'h000005, 24'h000003, 24'h000000, 6'b000000, 1, 0);

    // flush together with in_valid in IDLE: nothing is accepted
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd0;
    bus.opA      = 24'd1;
    bus.opB      = 24'd1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    chk("flush_idle in_ready", 32'(bus.in_ready), 32'd1);
    watch_no_valid("flush_idle no_valid", 5);

    // flush in cycle 10 of a mul
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd6;
    bus.opA      = 24'd3;
    bus.opB      = 24'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_mul busy", 32'(bus.in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_mul in_ready", 32'(bus.in_ready), 32'd1);
    watch_no_valid("flush_mul no_valid", 30);

    // reset in the middle of a divide; result still holds rsvd's 0, so
    // first leave a nonzero result behind
    run("pre_rst",   4'd0,  24'h000010, 24'h000002, 24'h000012, 6'b000000, 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd9;
    bus.opA      = 24'd100;
    bus.opB      = 24'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_div out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_div result", 32'(bus.result), 32'd0);
    chk("rst_div flags", 32'(flags()), 32'd0);
    chk("rst_div in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_valid("rst_div no_valid", 30);

    // block is usable after the abort
    run("post_rst",  4'd6,  24'd7,      24'd6,      24'd42,     6'b000000, 25, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
